// File: rtl/data_mem.sv
// Byte-addressable little-endian data memory for the single-cycle RV32I core.
// Handles byte, halfword and word loads and stores. Load data is sign- or
// zero-extended. Faulting accesses are flagged, and faulting stores are dropped.
module data_mem #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_we,
    input  logic        mem_re,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [2:0]  funct3,
    output logic [31:0] rdata,
    output logic        misaligned,
    output logic        illegal
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [31:0]       mem [DEPTH];
    logic [ADDR_W-1:0] idx;
    logic [1:0]        lane;
    logic [31:0]       rword;
    logic [7:0]        bsel;
    logic [15:0]       hsel;
    logic              is_half;
    logic              is_word;
    logic              align_bad;
    logic              load_ill;
    logic              store_ill;
    logic              load_ok;
    logic              store_ok;
    logic [3:0]        be;
    logic [31:0]       wd;
    logic              unused_hi;

    // Address bits above the array size are dropped, so accesses wrap.
    assign idx       = addr[ADDR_W+1:2];
    assign lane      = addr[1:0];
    assign unused_hi = ^addr[31:ADDR_W+2];

    // Decode the access size and the alignment and legality faults
    always_comb begin
        is_half   = (funct3 == 3'b001) || (funct3 == 3'b101);
        is_word   = (funct3 == 3'b010);
        align_bad = (is_half && addr[0]) || (is_word && (lane != 2'b00));
        load_ill  = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
        store_ill = !((funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010));
        load_ok   = mem_re && !load_ill && !align_bad;
        store_ok  = mem_we && !store_ill && !align_bad;
        illegal    = (mem_re && load_ill) || (mem_we && store_ill);
        misaligned = (mem_re || mem_we) && align_bad;
    end

    // Load path: pick the addressed lane(s), then extend per funct3
    always_comb begin
        rword = mem[idx];
        bsel  = rword[{lane, 3'b000} +: 8];
        hsel  = addr[1] ? rword[31:16] : rword[15:0];
        rdata = '0;
        if (load_ok) begin
            case (funct3)
                3'b000:  rdata = {{24{bsel[7]}}, bsel};
                3'b001:  rdata = {{16{hsel[15]}}, hsel};
                3'b010:  rdata = rword;
                3'b100:  rdata = {24'h000000, bsel};
                3'b101:  rdata = {16'h0000, hsel};
                default: rdata = '0;
            endcase
        end
    end

    // Store path: replicate the store data across lanes and build lane enables
    always_comb begin
        be = '0;
        wd = wdata;
        case (funct3)
            3'b000: begin
                be = 4'b0001 << lane;
                wd = {4{wdata[7:0]}};
            end
            3'b001: begin
                be = addr[1] ? 4'b1100 : 4'b0011;
                wd = {2{wdata[15:0]}};
            end
            3'b010: begin
                be = 4'b1111;
                wd = wdata;
            end
            default: be = '0;
        endcase
        if (!store_ok) begin
            be = '0;
        end
    end

    // Storage array: reset clears every word, stores write the enabled lanes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[ADDR_W'(i)] <= '0;
            end
        end else begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[idx][8*b +: 8] <= wd[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_mem.sv
// Self-checking bench for data_mem. Expected outputs are queued when stimulus
// is driven, then popped and compared once the combinational outputs settle.
module tb_data_mem;

    logic        clk;
    logic        rst;
    logic        mem_we;
    logic        mem_re;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  funct3;
    logic [31:0] rdata;
    logic        misaligned;
    logic        illegal;

    typedef struct {
        string       tag;
        logic [31:0] rd;
        logic        mis;
        logic        ill;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    localparam logic [2:0] F_B  = 3'b000;
    localparam logic [2:0] F_H  = 3'b001;
    localparam logic [2:0] F_W  = 3'b010;
    localparam logic [2:0] F_BU = 3'b100;
    localparam logic [2:0] F_HU = 3'b101;

    data_mem #(.ADDR_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .mem_we     (mem_we),
        .mem_re     (mem_re),
        .addr       (addr),
        .wdata      (wdata),
        .funct3     (funct3),
        .rdata      (rdata),
        .misaligned (misaligned),
        .illegal    (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input string tag, input logic [31:0] rd, input logic mis, input logic ill);
        exp_t e;
        e.tag = tag;
        e.rd  = rd;
        e.mis = mis;
        e.ill = ill;
        sb.push_back(e);
    endtask

    task automatic pop_cmp();
        exp_t e;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk({e.tag, ".rdata"}, rdata, e.rd);
            chk({e.tag, ".mis"}, {31'd0, misaligned}, {31'd0, e.mis});
            chk({e.tag, ".ill"}, {31'd0, illegal}, {31'd0, e.ill});
        end
    endtask

    // Store: flags are checked before the edge, then the edge commits it
    task automatic store(input string tag, input logic [31:0] a, input logic [31:0] d,
                         input logic [2:0] f, input logic exp_mis, input logic exp_ill);
        @(negedge clk);
        mem_we = 1'b1;
        mem_re = 1'b0;
        addr   = a;
        wdata  = d;
        funct3 = f;
        push_exp(tag, 32'h0, exp_mis, exp_ill);
        #1;
        pop_cmp();
        @(posedge clk);
        #1;
        mem_we = 1'b0;
    endtask

    task automatic load(input string tag, input logic [31:0] a, input logic [2:0] f,
                        input logic [31:0] exp_rd, input logic exp_mis, input logic exp_ill);
        @(negedge clk);
        mem_we = 1'b0;
        mem_re = 1'b1;
        addr   = a;
        funct3 = f;
        push_exp(tag, exp_rd, exp_mis, exp_ill);
        #1;
        pop_cmp();
        mem_re = 1'b0;
    endtask

    initial begin
        rst    = 1'b1;
        mem_we = 1'b0;
        mem_re = 1'b0;
        addr   = '0;
        wdata  = '0;
        funct3 = F_W;
        #1;
        push_exp("in_reset_idle", 32'h0, 1'b0, 1'b0);
        pop_cmp();
        #11;
        rst = 1'b0;

        load("reset_lw10", 32'h10, F_W, 32'h0, 1'b0, 1'b0);

        store("sw20", 32'h20, 32'h8899AABB, F_W, 1'b0, 1'b0);
        load("lb20",  32'h20, F_B,  32'hFFFFFFBB, 1'b0, 1'b0);
        load("lbu21", 32'h21, F_BU, 32'h000000AA, 1'b0, 1'b0);
        load("lh22",  32'h22, F_H,  32'hFFFF8899, 1'b0, 1'b0);
        load("lhu22", 32'h22, F_HU, 32'h00008899, 1'b0, 1'b0);
        load("lw20",  32'h20, F_W,  32'h8899AABB, 1'b0, 1'b0);
        load("lb23",  32'h23, F_B,  32'hFFFFFF88, 1'b0, 1'b0);
        load("lh20",  32'h20, F_H,  32'hFFFFAABB, 1'b0, 1'b0);

        store("sw30", 32'h30, 32'h11223344, F_W, 1'b0, 1'b0);
        store("sb31", 32'h31, 32'hFFFFFFEE, F_B, 1'b0, 1'b0);
        store("sh32", 32'h32, 32'hABCD5566, F_H, 1'b0, 1'b0);
        load("lw30_merge", 32'h30, F_W, 32'h5566EE44, 1'b0, 1'b0);

        store("sw40", 32'h40, 32'hA5A5A5A5, F_W, 1'b0, 1'b0);
        store("sh41_mis", 32'h41, 32'h00001234, F_H, 1'b1, 1'b0);
        load("lw40_after_mis", 32'h40, F_W, 32'hA5A5A5A5, 1'b0, 1'b0);
        store("sw43_mis", 32'h43, 32'h00000000, F_W, 1'b1, 1'b0);
        store("st_f100_ill", 32'h40, 32'h00000000, F_BU, 1'b0, 1'b1);
        load("lw40_after_ill", 32'h40, F_W, 32'hA5A5A5A5, 1'b0, 1'b0);

        load("lw42_mis", 32'h42, F_W, 32'h0, 1'b1, 1'b0);
        load("lh43_mis", 32'h43, F_H, 32'h0, 1'b1, 1'b0);
        load("lb43_ok",  32'h43, F_B, 32'hFFFFFFA5, 1'b0, 1'b0);
        load("ld_f111_ill", 32'h40, 3'b111, 32'h0, 1'b0, 1'b1);
        load("ld_f011_ill", 32'h40, 3'b011, 32'h0, 1'b0, 1'b1);

        store("sw404_wrap", 32'h404, 32'hCAFEF00D, F_W, 1'b0, 1'b0);
        load("lw004_alias", 32'h004, F_W, 32'hCAFEF00D, 1'b0, 1'b0);
        load("lw804_alias", 32'h804, F_W, 32'hCAFEF00D, 1'b0, 1'b0);

        // Simultaneous store and load: old data before the edge, new data after it
        @(negedge clk);
        mem_we = 1'b1;
        mem_re = 1'b1;
        addr   = 32'h30;
        wdata  = 32'hDEADBEEF;
        funct3 = F_W;
        push_exp("rw_before_edge", 32'h5566EE44, 1'b0, 1'b0);
        #1;
        pop_cmp();
        @(posedge clk);
        #1;
        mem_we = 1'b0;
        push_exp("rw_after_edge", 32'hDEADBEEF, 1'b0, 1'b0);
        pop_cmp();
        mem_re = 1'b0;

        // Reset raised while a store is pending: the array clears, the write is lost
        @(negedge clk);
        mem_we = 1'b1;
        mem_re = 1'b0;
        addr   = 32'h004;
        wdata  = 32'h12345678;
        funct3 = F_W;
        #2;
        rst = 1'b1;
        @(posedge clk);
        #2;
        rst    = 1'b0;
        mem_we = 1'b0;
        load("lw004_post_rst", 32'h004, F_W, 32'h0, 1'b0, 1'b0);
        load("lw20_post_rst",  32'h020, F_W, 32'h0, 1'b0, 1'b0);

        store("sw08_resume", 32'h008, 32'h00000077, F_W, 1'b0, 1'b0);
        load("lw08_resume", 32'h008, F_W, 32'h00000077, 1'b0, 1'b0);

        // Load disabled: rdata stays zero even over non-zero contents
        @(negedge clk);
        mem_re = 1'b0;
        addr   = 32'h008;
        funct3 = F_W;
        push_exp("re_low", 32'h0, 1'b0, 1'b0);
        #1;
        pop_cmp();

        if (sb.size() != 0) begin
            chk("scoreboard_leftover", sb.size(), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_mem.md
# data_mem

Byte-addressable data memory for the single-cycle RV32I core. It services loads and stores, with RISC-V byte, halfword and word sizing, and alignment checking. Load data is sign- or zero-extended here. The extended word goes to the writeback result-select path as the memory source. Store data comes from rs2 and addresses come from the ALU result.

## Interface
- `ADDR_W`, default 8: log2 of the number of 32-bit words. The default gives 256 words, 1 KiB.
- `clk`, input, 1: clock. All writes happen on the rising edge.
- `rst`, input, 1: asynchronous, active-high reset. It clears every memory word to 0.
- `mem_we`, input, 1: store enable.
- `mem_re`, input, 1: load enable. It gates `rdata` and the fault flags for loads.
- `addr`, input, 32: byte address, taken from the ALU result.
- `wdata`, input, 32: store data from rs2. Only the low byte or halfword is used for SB and SH.
- `funct3`, input, 3: access size and extension.
- `rdata`, output, 32: extended load data. Combinational.
- `misaligned`, output, 1: access alignment fault. Combinational.
- `illegal`, output, 1: unsupported `funct3` for the active access. Combinational.

## Operation
- Storage is a `2**ADDR_W` × 32 array, little-endian.
- Word index is `addr[ADDR_W+1:2]`. Byte lane is `addr[1:0]`.
- Address bits above `ADDR_W+1` are ignored, so accesses wrap modulo the memory size.
- `funct3` decode:
  - 000: LB / SB
  - 001: LH / SH
  - 010: LW / SW
  - 100: LBU
  - 101: LHU
- `illegal` = 1 when the access is active and `funct3` is not a valid code for it:
  - For loads (`mem_re`=1): `funct3` ∈ {011, 110, 111}.
  - For stores (`mem_we`=1): `funct3` ∉ {000, 001, 010}. LBU/LHU codes used on a store are illegal.
- `misaligned` = 1 when the access is active and either:
  - it is a halfword access with `addr[0]`=1, or
  - it is a word access with `addr[1:0]`≠00.
- Byte accesses never fault.
- Store behaviour (`mem_we`=1, no fault, at the rising edge):
  - SB writes `wdata[7:0]` into the lane selected by `addr[1:0]`.
  - SH writes `wdata[15:0]` into lanes {1:0} or {3:2}, chosen by `addr[1]`.
  - SW writes all 4 lanes.
  - Unselected lanes are unchanged.
- Faulting stores are suppressed: no write occurs.
- Load behaviour (`mem_re`=1, no fault):
  - Select the byte or halfword from the addressed word.
  - LB and LH sign-extend from bit 7 or bit 15.
  - LBU and LHU zero-extend.
  - LW returns the word as stored.
- `rdata` = 0 when `mem_re`=0, or when the load faults.
- If `mem_we` and `mem_re` are both 1: the store takes effect at the edge. `rdata` shows the old contents until that edge, then the new contents. There is no bypass.
- The fault flags are the OR over the active operations.

## Timing
- Reads are combinational, with zero-cycle latency from `addr`, `funct3` and `mem_re` to `rdata`.
- Writes commit on the `clk` rising edge and are visible on `rdata` combinationally after that edge.
- Reset values:
  - All array words are 0.
  - `rdata` = 0, `misaligned` = 0, `illegal` = 0. These follow from the inputs, because the outputs are combinational.
- Reset asserted during a store:
  - Reset wins. The array is cleared and the edge write is discarded while `rst`=1.
  - Writes resume on the first rising edge after `rst` is released.
- Wrap-around: with `ADDR_W`=8, address 0x400 aliases 0x000.

## Test plan
- Reset, then LW at 0x10 → `rdata` = 0x00000000, `misaligned` = 0, `illegal` = 0.
- SW 0x8899AABB at 0x20, then:
  - LB at 0x20 → 0xFFFFFFBB
  - LBU at 0x21 → 0x000000AA
  - LH at 0x22 → 0xFFFF8899
  - LHU at 0x22 → 0x00008899
- SW 0x11223344 at 0x30, SB 0xEE at 0x31, SH 0x5566 at 0x32, then LW at 0x30 → 0x5566EE44.
- Misaligned accesses:
  - SH at 0x41 → `misaligned` = 1 and the word at 0x40 is unchanged.
  - LW at 0x42 → `rdata` = 0, `misaligned` = 1.
- Illegal codes:
  - Store with `funct3`=100 → `illegal` = 1 and no write.
  - Load with `funct3`=111 → `illegal` = 1 and `rdata` = 0.
- Wrap and reset:
  - SW 0xCAFEF00D at 0x404, then LW at 0x004 → 0xCAFEF00D.
  - Assert `rst` mid-cycle while SW is pending → LW at 0x004 returns 0.
